// File: rtl/ps2_scan_decode_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder: prefix/control bytes,
// decoder state encoding and the 10-bit key event record.
package ps2_pkg;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_FE = 8'hFE;
    localparam logic [7:0] B_EE = 8'hEE;
    localparam logic [7:0] B_00 = 8'h00;
    localparam logic [7:0] B_FF = 8'hFF;

    // Bytes swallowed after E1 (the remainder of the Pause/Break sequence)
    localparam int         SKIP_W     = 3;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;

    typedef struct packed {
        logic [7:0] key;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_scan_decode_if.sv
// Byte-in / event-out bundle of the PS/2 scan-code decoder.
interface ps2_scan_decode_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_rd;
    logic       o_valid;
    logic [7:0] o_key;
    logic       o_ext;
    logic       o_brk;
    logic       o_err;
    logic       o_ovf;

    modport master (
        output i_valid, i_data, i_rd,
        input  o_valid, o_key, o_ext, o_brk, o_err, o_ovf
    );

    modport slave (
        input  i_valid, i_data, i_rd,
        output o_valid, o_key, o_ext, o_brk, o_err, o_ovf
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with sticky overflow; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     sclr,
    input  logic     push,
    input  ps2_evt_t push_evt,
    input  logic     pop,
    output ps2_evt_t head_evt,
    output logic     empty,
    output logic     ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    ps2_evt_t        mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            pop_ok;
    logic            push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop_ok  = pop && !empty;
    // Full FIFO still takes a push when the head leaves in the same edge
    assign push_ok = push && (!full || pop_ok);
    assign head_evt = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !sclr) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (sclr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
            if (push && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_scan_decode.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into key events, swallows the
// Pause/Break sequence, flags 00/FF errors and queues events in a small FIFO.
module ps2_scan_decode
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_sclr,
    ps2_scan_decode_if.slave  bus
);
    logic [2:0]        st;
    logic [2:0]        nxt_st;
    logic [SKIP_W-1:0] skip;
    logic [SKIP_W-1:0] nxt_skip;
    logic              push;
    ps2_evt_t          push_evt;
    logic              err_d;
    logic              err_p1;
    ps2_evt_t          head_evt;
    logic              fifo_empty;
    logic              fifo_ovf;
    logic              is_ext;
    logic              is_brk;
    logic              is_ack;

    assign is_ext = (st == ST_EXT) || (st == ST_EXT_BRK);
    assign is_brk = (st == ST_BRK) || (st == ST_EXT_BRK);
    assign is_ack = (bus.i_data == B_AA) || (bus.i_data == B_FA) ||
                    (bus.i_data == B_FE) || (bus.i_data == B_EE);

    always_comb begin
        nxt_st   = st;
        nxt_skip = skip;
        push     = 1'b0;
        push_evt = '{key: bus.i_data, ext: is_ext, brk: is_brk};
        err_d    = 1'b0;
        if (bus.i_valid) begin
            if (st == ST_PAUSE) begin
                nxt_skip = skip - SKIP_W'(1);
                if (skip <= SKIP_W'(1)) begin
                    nxt_st   = ST_IDLE;
                    nxt_skip = '0;
                end
            end else if ((bus.i_data == B_00) || (bus.i_data == B_FF)) begin
                err_d  = 1'b1;
                nxt_st = ST_IDLE;
            end else if (bus.i_data == B_E0) begin
                // A stray F0 before E0 is discarded; F0 then E0 after E0 keeps the break
                nxt_st = (st == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
            end else if (bus.i_data == B_F0) begin
                if (st == ST_IDLE) begin
                    nxt_st = ST_BRK;
                end else if (st == ST_EXT) begin
                    nxt_st = ST_EXT_BRK;
                end
            end else if ((bus.i_data == B_E1) && (st == ST_IDLE)) begin
                push     = 1'b1;
                push_evt = '{key: B_E1, ext: 1'b0, brk: 1'b0};
                nxt_skip = PAUSE_SKIP;
                nxt_st   = ST_PAUSE;
            end else if (is_ack && (st == ST_IDLE)) begin
                nxt_st = ST_IDLE;
            end else begin
                push   = 1'b1;
                nxt_st = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st     <= ST_IDLE;
            skip   <= '0;
            err_p1 <= 1'b0;
        end else if (i_sclr) begin
            st     <= ST_IDLE;
            skip   <= '0;
            err_p1 <= 1'b0;
        end else begin
            st     <= nxt_st;
            skip   <= nxt_skip;
            err_p1 <= err_d;
        end
    end

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .sclr     (i_sclr),
        .push     (push),
        .push_evt (push_evt),
        .pop      (bus.i_rd),
        .head_evt (head_evt),
        .empty    (fifo_empty),
        .ovf      (fifo_ovf)
    );

    assign bus.o_valid = !fifo_empty;
    assign bus.o_key   = head_evt.key;
    assign bus.o_ext   = head_evt.ext;
    assign bus.o_brk   = head_evt.brk;
    assign bus.o_err   = err_p1;
    assign bus.o_ovf   = fifo_ovf;
endmodule
